// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core pipeline.
//   INSTR_W   : instruction / address width
//   PC_INC    : sequential fetch increment
//   RESET_PC  : default PC loaded on reset
//   NOP_INSTR : default bubble instruction (sll $0,$0,0)
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Fetch addresses are word aligned; redirect targets drop their low bits.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Bus between the fetch/decode stage and the rest of the core.
//   master : the fetch stage (drives PCF, Decode-side outputs and counters)
//   slave  : environment (stall controller, Decode redirect, instruction memory)
interface fetch_decode_stage_if
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic               StallF;
  logic               StallD;
  logic               PCSrcD;
  logic [INSTR_W-1:0] PCBranchD;
  logic               JumpD;
  logic [INSTR_W-1:0] PCJumpD;
  logic [INSTR_W-1:0] InstrF;
  logic [INSTR_W-1:0] PCF;
  logic [INSTR_W-1:0] InstrD;
  logic [INSTR_W-1:0] PCPlus4D;
  logic               ValidD;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    input  StallF, StallD, PCSrcD, PCBranchD, JumpD, PCJumpD, InstrF,
    output PCF, InstrD, PCPlus4D, ValidD, stall_cnt, flush_cnt
  );

  modport slave (
    output StallF, StallD, PCSrcD, PCBranchD, JumpD, PCJumpD, InstrF,
    input  PCF, InstrD, PCPlus4D, ValidD, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with load enable and asynchronous reset.
//   clk, rst_n : clock, async active-low reset (loads RESET_VAL)
//   en         : load pc_next this cycle
//   pc_next    : next PC value (selected outside)
//   pc         : current PC
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VAL = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [INSTR_W-1:0] pc_next,
  output logic [INSTR_W-1:0] pc
);

  logic [INSTR_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else if (en) begin
      pc_q <= pc_next;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset
//   bus        : master side of fetch_decode_stage_if
//                in : StallF, StallD, PCSrcD/PCBranchD, JumpD/PCJumpD, InstrF
//                out: PCF, InstrD, PCPlus4D, ValidD, stall_cnt, flush_cnt
// Next PC: hold on StallF, else branch target, else jump target, else PC+4.
// Decode is flushed on a taken redirect unless Decode itself is stalled.
// Counters saturate at all-ones.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_decode_stage_if.master bus
);

  localparam int unsigned W = mips_pkg::INSTR_W;

  logic [W-1:0]     pcf;
  logic [W-1:0]     pc_plus4f;
  logic [W-1:0]     redirect_target;
  logic [W-1:0]     pc_next;
  logic             redirect;
  logic             flush_d;

  logic [W-1:0]     instr_d_q;
  logic [W-1:0]     pc_plus4_d_q;
  logic             valid_d_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4f = pcf + mips_pkg::PC_INC;

  assign redirect = bus.PCSrcD | bus.JumpD;

  always_comb begin
    redirect_target = '0;
    pc_next         = pc_plus4f;
    // Branch outranks jump when both are flagged.
    if (bus.PCSrcD) begin
      redirect_target = mips_pkg::word_align(bus.PCBranchD);
    end else begin
      redirect_target = mips_pkg::word_align(bus.PCJumpD);
    end
    if (redirect) begin
      pc_next = redirect_target;
    end
  end

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (~bus.StallF),
    .pc_next (pc_next),
    .pc      (pcf)
  );

  // A stalled Decode keeps the redirecting instruction, so it is re-presented
  // next cycle; flushing now would lose it.
  assign flush_d = redirect & ~bus.StallD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d_q    <= NOP_INSTR;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
    end else if (bus.StallD) begin
      instr_d_q    <= instr_d_q;
      pc_plus4_d_q <= pc_plus4_d_q;
      valid_d_q    <= valid_d_q;
    end else if (flush_d) begin
      instr_d_q    <= NOP_INSTR;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
    end else begin
      instr_d_q    <= bus.InstrF;
      pc_plus4_d_q <= pc_plus4f;
      valid_d_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_d && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.PCF       = pcf;
  assign bus.InstrD    = instr_d_q;
  assign bus.PCPlus4D  = pc_plus4_d_q;
  assign bus.ValidD    = valid_d_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // Holding PC while Decode advances would duplicate an instruction.
  illegal_stall_combo : assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.StallF && !bus.StallD)
  ) else $error("StallF asserted without StallD");

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  fetch_decode_stage_if #(.CNT_W(16)) u_if ();
  fetch_decode_stage_if #(.CNT_W(2))  u_if2 ();

  fetch_decode_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  fetch_decode_stage #(
    .RESET_PC  (32'hFFFF_FFFC),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (u_if2.master)
  );

  // Combinational instruction memory: word = address with a tag in the top bits.
  always_comb u_if.InstrF  = u_if.PCF  | 32'hA000_0000;
  always_comb u_if2.InstrF = u_if2.PCF | 32'hA000_0000;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic [31:0] sc,
                         input logic [31:0] fc);
    chk({tag, ".PCF"},       u_if.PCF,                 pcf);
    chk({tag, ".InstrD"},    u_if.InstrD,              instr);
    chk({tag, ".PCPlus4D"},  u_if.PCPlus4D,            pc4);
    chk({tag, ".ValidD"},    {31'd0, u_if.ValidD},     {31'd0, valid});
    chk({tag, ".stall_cnt"}, {16'd0, u_if.stall_cnt},  sc);
    chk({tag, ".flush_cnt"}, {16'd0, u_if.flush_cnt},  fc);
  endtask

  task automatic chk_all2(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid, input logic [1:0] sc,
                          input logic [1:0] fc);
    chk({tag, ".PCF"},       u_if2.PCF,                pcf);
    chk({tag, ".InstrD"},    u_if2.InstrD,             instr);
    chk({tag, ".PCPlus4D"},  u_if2.PCPlus4D,           pc4);
    chk({tag, ".ValidD"},    {31'd0, u_if2.ValidD},    {31'd0, valid});
    chk({tag, ".stall_cnt"}, {30'd0, u_if2.stall_cnt}, {30'd0, sc});
    chk({tag, ".flush_cnt"}, {30'd0, u_if2.flush_cnt}, {30'd0, fc});
  endtask

  typedef struct {
    logic        stallf;
    logic        stalld;
    logic        pcsrc;
    logic [31:0] branch;
    logic        jump;
    logic [31:0] jtarget;
    logic [31:0] e_pcf;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    // stF stD br  target        jmp target        PCF           InstrD        PC4D  V  sc fc
    vecs[0]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h04,  32'hA000_0000, 32'h04,  1, 0, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h08,  32'hA000_0004, 32'h08,  1, 0, 0};
    vecs[2]  = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h08,  32'hA000_0004, 32'h08,  1, 1, 0};
    vecs[3]  = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h08,  32'hA000_0004, 32'h08,  1, 2, 0};
    vecs[4]  = '{1, 1, 0, 32'h0,   0, 32'h0,   32'h08,  32'hA000_0004, 32'h08,  1, 3, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h0C,  32'hA000_0008, 32'h0C,  1, 3, 0};
    vecs[6]  = '{0, 0, 1, 32'h40,  0, 32'h0,   32'h40,  32'h0,         32'h0,   0, 3, 1};
    vecs[7]  = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h44,  32'hA000_0040, 32'h44,  1, 3, 1};
    // Redirect under stall: held, no flush counted.
    vecs[8]  = '{1, 1, 1, 32'h80,  0, 32'h0,   32'h44,  32'hA000_0040, 32'h44,  1, 4, 1};
    vecs[9]  = '{0, 0, 1, 32'h80,  0, 32'h0,   32'h80,  32'h0,         32'h0,   0, 4, 2};
    // Jump with unaligned target.
    vecs[10] = '{0, 0, 0, 32'h0,   1, 32'h103, 32'h100, 32'h0,         32'h0,   0, 4, 3};
    // Branch and jump together: branch wins, one flush.
    vecs[11] = '{0, 0, 1, 32'h202, 1, 32'h300, 32'h200, 32'h0,         32'h0,   0, 4, 4};
    vecs[12] = '{0, 0, 0, 32'h0,   0, 32'h0,   32'h204, 32'hA000_0200, 32'h204, 1, 4, 4};

    u_if.StallF = 0; u_if.StallD = 0; u_if.PCSrcD = 0; u_if.PCBranchD = 0;
    u_if.JumpD = 0;  u_if.PCJumpD = 0;
    u_if2.StallF = 0; u_if2.StallD = 0; u_if2.PCSrcD = 0; u_if2.PCBranchD = 0;
    u_if2.JumpD = 0;  u_if2.PCJumpD = 0;
    rst_n = 0;
    rst2_n = 0;
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    chk_all2("reset2", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NV; i++) begin
      u_if.StallF    = vecs[i].stallf;
      u_if.StallD    = vecs[i].stalld;
      u_if.PCSrcD    = vecs[i].pcsrc;
      u_if.PCBranchD = vecs[i].branch;
      u_if.JumpD     = vecs[i].jump;
      u_if.PCJumpD   = vecs[i].jtarget;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_instr, vecs[i].e_pc4,
              vecs[i].e_valid, vecs[i].e_stall, vecs[i].e_flush);
    end

    // DUT2: PC wraps from FFFF_FFFC to 0.
    rst2_n = 1;
    step();
    chk_all2("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 2'd0, 2'd0);
    step();
    chk_all2("wrap+1", 32'h4, 32'hA000_0000, 32'h4, 1'b1, 2'd0, 2'd0);

    // Stall counter saturates at 3.
    u_if2.StallF = 1; u_if2.StallD = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat.stall_cnt", {30'd0, u_if2.stall_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("sat.PCF_held", u_if2.PCF, 32'h4);

    // Async reset mid-stall: outputs return before the next edge.
    rst2_n = 0;
    #1;
    chk_all2("async_rst", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
    @(negedge clk);
    rst2_n = 1;
    u_if2.StallF = 0; u_if2.StallD = 0;
    step();
    chk_all2("post_rst", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 2'd0, 2'd0);

    // Flush counter saturates at 3 after four jumps.
    u_if2.JumpD = 1; u_if2.PCJumpD = 32'h0000_0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat.flush_cnt", {30'd0, u_if2.flush_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("jump.PCF", u_if2.PCF, 32'h10);
    chk("jump.ValidD", {31'd0, u_if2.ValidD}, 32'd0);
    u_if2.JumpD = 0;

    // Async reset mid-flush on DUT1.
    u_if.JumpD = 1; u_if.PCJumpD = 32'h0000_0500;
    step();
    rst_n = 0;
    #1;
    chk_all("rst_mid_flush", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    u_if.JumpD = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    chk_all("first_fetch", 32'h4, 32'hA000_0000, 32'h4, 1'b1, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC register and next-PC selection, and drives the instruction-memory address.
- Captures the fetched instruction into the Decode stage.
- Consumes StallF/StallD from the stall controller and branch/jump redirects resolved in Decode.
- Provides saturating stall/flush performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into Decode on flush/reset (sll $0,$0,0).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- StallF  input  1  hold PC register.
- StallD  input  1  hold IF/ID register.
- PCSrcD  input  1  branch taken, resolved in Decode.
- PCBranchD  input  32  branch target.
- JumpD  input  1  jump in Decode.
- PCJumpD  input  32  jump target.
- InstrF  input  32  instruction-memory read data for PCF (combinational read).
- PCF  output  32  current fetch address to instruction memory.
- InstrD  output  32  instruction in Decode.
- PCPlus4D  output  32  PC+4 of the Decode instruction.
- ValidD  output  1  Decode slot holds a real instruction (0 = bubble).
- stall_cnt  output  CNT_W  cycles with StallF=1.
- flush_cnt  output  CNT_W  Decode flushes performed.

Behaviour:
- Reset (rst_n=0, async): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, stall_cnt=0, flush_cnt=0.
- PCPlus4F = PCF+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Next-PC priority, registered each clock:
  - StallF: hold.
  - else PCSrcD: PCBranchD.
  - else JumpD: PCJumpD.
  - else PCPlus4F.
- Targets have bits[1:0] forced to 0 before loading.
- FlushD = (PCSrcD | JumpD) & ~StallD.
- IF/ID register priority:
  - StallD: hold InstrD, PCPlus4D, ValidD.
  - else FlushD: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - else load InstrF, PCPlus4F, ValidD=1.
- Latency: instruction at PCF appears on InstrD one cycle later, absent stall/flush.
- StallD together with PCSrcD/JumpD: stall wins. No flush, no count; the redirect is re-presented next cycle.
- StallF=1 with StallD=0 is illegal from the stall controller. The block still obeys the rules above, and a simulation assertion flags it.
- PCSrcD and JumpD both high: branch target wins; one flush counted.
- stall_cnt increments when StallF=1; flush_cnt increments when FlushD=1. Both saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush returns every output to its reset value immediately. First fetch after release is RESET_PC.

Decomposition:
- Shared package mips_pkg holds NOP_INSTR, RESET_PC, instruction width constant 32, and the PC-increment constant 4.
- One natural sub-module: pc_reg (PC register with enable and async reset, next-PC mux outside it).
- IF/ID register and counters stay inline.

Test Plan:
- Reset, then 4 free-running cycles with InstrF=PCF|32'hA000_0000 -> PCF 0,4,8,C; InstrD lags by one cycle; ValidD=1 from second cycle.
- StallF=StallD=1 for 3 cycles at PCF=8 -> PCF stays 8, InstrD held, stall_cnt=3, flush_cnt=0.
- PCSrcD=1, PCBranchD=32'h40 at PCF=C -> next PCF=40, InstrD=NOP_INSTR, ValidD=0, flush_cnt=1.
- PCSrcD=1 and StallD=StallF=1 same cycle, then stall drops -> no flush during stall; redirect to target on release; flush_cnt increments once.
- JumpD=1, PCJumpD=32'h103; then RESET_PC=32'hFFFF_FFFC with free run -> PCF=100 (low bits masked); PCF wraps to 0.
- CNT_W=2, StallF held 6 cycles -> stall_cnt saturates at 3; rst_n pulsed low mid-stall -> all outputs reset asynchronously, before next clock edge.
